// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
//   Accepts per-instruction field requests, encodes them into 16-bit
//   instruction words, and writes them sequentially into instruction
//   memory through a small FIFO. It stops after HLT (opcode F) once the
//   FIFO has drained. Malformed requests raise a sticky error.
//
// Parameters
//   FIFO_DEPTH : encoded-word buffer entries (power of 2, >= 2)
//   ERR_W      : width of err_code
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start, start_addr : begin a stream at {start_addr[15:1],0}
//   in_valid/in_ready : field request handshake
//   opcode,rd,rs,rt,imm,cc,target : instruction fields
//   mem_wr_en, mem_addr, mem_wdata, mem_ready : memory write port
//   done              : HLT written and buffer empty
//   err, err_code     : sticky error, first cause (1 imm, 2 B range, 3 B odd)
//   instr_count       : words written (saturating)
module instr_stream_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      start_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       rd,
  input  logic [3:0]       rs,
  input  logic [3:0]       rt,
  input  logic [15:0]      imm,
  input  logic [2:0]       cc,
  input  logic [15:0]      target,
  output logic             mem_wr_en,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic             mem_ready,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_code,
  output logic [15:0]      instr_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [15:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       count;
  logic [15:0]       enc_addr, wr_addr;
  logic              err_q;
  logic [ERR_W-1:0]  err_code_q;
  logic [15:0]       cnt_q;

  logic              fifo_full, fifo_empty;
  logic              accept, push, pop;
  logic signed [16:0] off_c;
  logic [1:0]        req_err_c;
  logic [15:0]       word_c;

  // Branch offset in 17-bit signed space so the wrap at 0xFFFE cannot alias.
  function automatic logic signed [16:0] branch_off(input logic [15:0] tgt,
                                                    input logic [15:0] pc);
    logic signed [16:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, pc} + 17'd2);
    return diff >>> 1;
  endfunction

  function automatic logic [1:0] req_err(input logic [3:0] op,
                                         input logic [15:0] im,
                                         input logic [15:0] tgt,
                                         input logic signed [16:0] off);
    logic [1:0] code;
    code = 2'd0;
    case (op)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9: if (im > 16'd15) code = 2'd1;
      4'hA, 4'hB:                   if (im > 16'd255) code = 2'd1;
      4'hC: begin
        if (tgt[0])
          code = 2'd3;
        else if ((off < -17'sd256) || (off > 17'sd255))
          code = 2'd2;
      end
      default: code = 2'd0;
    endcase
    return code;
  endfunction

  function automatic logic [15:0] encode(input logic [3:0] op,
                                         input logic [3:0] f_rd,
                                         input logic [3:0] f_rs,
                                         input logic [3:0] f_rt,
                                         input logic [15:0] im,
                                         input logic [2:0] f_cc,
                                         input logic signed [16:0] off);
    logic [15:0] w;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: w = {op, f_rd, f_rs, f_rt};
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9: w = {op, f_rd, f_rs, im[3:0]};
      4'hA, 4'hB:                   w = {op, f_rd, im[7:0]};
      4'hC:                         w = {op, f_cc, off[8:0]};
      4'hD:                         w = {op, f_cc, 1'b0, f_rs, 4'b0000};
      4'hE:                         w = {op, f_rd, 8'h00};
      default:                      w = 16'hF000;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // Ready depends only on registered state, never on a same-cycle pop.
  assign in_ready  = (state == RUN) && !fifo_full && !err_q;
  assign mem_wr_en = ((state == RUN) || (state == DRAIN)) && !fifo_empty;
  assign mem_wdata = mem_wr_en ? fifo_mem[rd_ptr] : 16'h0000;
  assign mem_addr  = wr_addr;
  assign done      = (state == DONE);
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign instr_count = cnt_q;

  assign off_c     = branch_off(target, enc_addr);
  assign req_err_c = req_err(opcode, imm, target, off_c);
  assign word_c    = encode(opcode, rd, rs, rt, imm, cc, off_c);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (req_err_c == 2'd0);
  assign pop       = mem_wr_en && mem_ready;

  // Stage p0: encoded word captured into the buffer at acceptance
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= word_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      enc_addr   <= 16'h0000;
      wr_addr    <= 16'h0000;
      err_q      <= 1'b0;
      err_code_q <= '0;
      cnt_q      <= 16'h0000;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            enc_addr <= {start_addr[15:1], 1'b0};
            wr_addr  <= {start_addr[15:1], 1'b0};
            cnt_q    <= 16'h0000;
          end
        end
        RUN:     if (push && (opcode == 4'hF)) state <= DRAIN;
        DRAIN:   if (fifo_empty) state <= DONE;
        default: state <= IDLE;
      endcase

      if (accept && (req_err_c != 2'd0)) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_W'(req_err_c);
      end

      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        enc_addr <= enc_addr + 16'd2;
      end

      // Stage p1: buffer head written to memory
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        wr_addr <= wr_addr + 16'd2;
        cnt_q   <= sat_inc(cnt_q);
      end

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/instr_stream_encoder.md
INSTR_STREAM_ENCODER -- requirements
Module: instr_stream_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, entries in the encoded-word buffer (power of 2, at least 2).
REQ-002 SHALL have parameter ERR_W, default 2, width of err_code.
REQ-003 SHALL have one clock and synchronous, active-high reset; ports clk and rst.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; load start_addr and begin a stream.
- start_addr  in  16  byte address of the first instruction; bit 0 ignored.
- in_valid  in  1  field request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both 1.
- opcode  in  4  instruction opcode.
- rd, rs, rt  in  4 each  register fields.
- imm  in  16  immediate (shift amount, LW/SW offset, LLB/LHB byte).
- cc  in  3  branch condition.
- target  in  16  absolute B target address.
- mem_wr_en  out  1  instruction-memory write strobe.
- mem_addr  out  16  write address.
- mem_wdata  out  16  encoded instruction.
- mem_ready  in  1  memory accepts the write this cycle.
- done  out  1  HLT written and buffer empty.
- err  out  1  sticky error flag.
- err_code  out  ERR_W  first error cause: 1 imm range, 2 B range, 3 B target odd.
- instr_count  out  16  instructions written to memory.

Function
REQ-005 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-006 IDLE: in_ready=0; start -> RUN, enc_addr and wr_addr set to {start_addr[15:1],0}, instr_count cleared.
REQ-007 RUN: in_ready = !fifo_full && !err; HLT accepted -> DRAIN.
REQ-008 DRAIN: in_ready=0; buffer empty after the last write -> DONE.
REQ-009 DONE: done=1, in_ready=0; start -> RUN using the new start_addr; err is not cleared.
REQ-010 start in RUN or DRAIN SHALL be ignored.
REQ-011 Encoding SHALL occur at acceptance; word pushed into FIFO, enc_addr += 2, wrap 0xFFFE -> 0x0000 with no flag.
REQ-012 Encoding rules:
- Opcodes 0-3, 7: {op, rd, rs, rt}.
- Opcodes 4-6, 8, 9: {op, rd, rs, imm[3:0]}.
- Opcodes A, B: {op, rd, imm[7:0]}.
- Opcode C: {op, cc, off9}.
- Opcode D: {op, cc, 0, rs, 0000}.
- Opcode E: {op, rd, 8'h00}.
- Opcode F: 0xF000.
REQ-013 B offset SHALL be off = (target - (enc_addr + 2)) >>> 1, computed in 17-bit signed arithmetic; legal range -256..+255.
REQ-014 Error checks on an accepted request, first match wins:
- imm > 15 for opcodes 4-6, 8, 9 -> code 1.
- imm > 255 for opcodes A, B -> code 1.
- target[0] = 1 -> code 3.
- off out of range -> code 2.
REQ-015 An erroring request SHALL be dropped (no push, enc_addr unchanged); err=1 and err_code latched on the first error only; state stays RUN with in_ready=0 until rst.
REQ-016 mem_wr_en = (FIFO not empty) in RUN or DRAIN; mem_wdata = FIFO head; mem_addr = wr_addr.
REQ-017 On mem_wr_en && mem_ready: pop, wr_addr += 2 (wrap as REQ-011), instr_count += 1 (saturate at 0xFFFF).
REQ-018 Latency: accept at cycle N -> mem_wr_en no earlier than N+1; with mem_ready=1, one write per cycle.
REQ-019 in_ready SHALL not depend on same-cycle pop; full FIFO stalls input even while popping.
REQ-020 mem_wdata and mem_addr SHALL stay stable while mem_wr_en=1 and mem_ready=0.

Reset
REQ-021 rst SHALL force, at the next edge, state IDLE, an empty FIFO, and all outputs 0: in_ready, mem_wr_en, mem_addr, mem_wdata, done, err, err_code, instr_count.
REQ-022 rst mid-stream SHALL discard buffered words without issuing any write.

Verification
REQ-023 start, start_addr=0x0000; ADD rd=3 rs=1 rt=2 -> write 0x0312 @0x0000; then LLB rd=5 imm=0xAB -> 0xA5AB @0x0002.
REQ-024 B cc=001 at enc_addr 0x0004, target 0x0010 -> 0xC205 @0x0004; target 0x0002 -> off -2 -> 0xC3FE.
REQ-025 mem_ready=0 with 5 requests offered -> exactly 4 accepted, in_ready=0, mem_wdata held; mem_ready=1 -> 4 writes in consecutive cycles, in order.
REQ-026 SLL imm=16 -> err=1, err_code=1, no write, in_ready=0; a later B odd target does not change err_code.
REQ-027 HLT after 2 instructions -> 0xF000 written, instr_count=3, done=1; start with 0xFFFE -> 2 writes @0xFFFE then @0x0000.
REQ-028 rst asserted with 3 words buffered -> no further mem_wr_en, all outputs 0 the next cycle.
